// File: rtl/atm_account_arbiter.sv
// Two-terminal shared-account controller: round-robin grant, deposit/withdraw
// with funds/overflow checks, and a four-phase ack carrying the resulting balance.
module atm_account_arbiter #(
  parameter int BAL_W    = 8,
  parameter int AMT_W    = 4,
  parameter int INIT_BAL = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [AMT_W-1:0] amt0,
  input  logic [1:0]       op1,
  input  logic [AMT_W-1:0] amt1,
  output logic [1:0]       gnt,
  output logic [1:0]       ack,
  output logic [BAL_W-1:0] balance_out,
  output logic             not_enough,
  output logic             err
);

  localparam logic [BAL_W-1:0] INIT_V   = BAL_W'(INIT_BAL);
  localparam logic [1:0]       OP_QUERY = 2'b00;
  localparam logic [1:0]       OP_DEP   = 2'b01;
  localparam logic [1:0]       OP_WDR   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             win_q, win_d;  // current/last granted terminal, doubles as RR pointer
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic             not_enough_q, not_enough_d;
  logic             err_q, err_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       ack_q, ack_d;

  logic             pick;
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W:0]   sum;

  assign amt_ext = BAL_W'(amt_q);
  assign sum     = {1'b0, bal_q} + {1'b0, amt_ext};

  always_comb begin
    pick = 1'b0;
    case (req)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~win_q;
      default: pick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      win_q        <= 1'b1;
      op_q         <= OP_QUERY;
      amt_q        <= '0;
      bal_q        <= INIT_V;
      not_enough_q <= 1'b0;
      err_q        <= 1'b0;
      gnt_q        <= 2'b00;
      ack_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      op_q         <= op_d;
      amt_q        <= amt_d;
      bal_q        <= bal_d;
      not_enough_q <= not_enough_d;
      err_q        <= err_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req != 2'b00) state_d = S_GRANT;
      S_GRANT: state_d = req[win_q] ? S_EXEC : S_IDLE;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (!req[win_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    win_d        = win_q;
    op_d         = op_q;
    amt_d        = amt_q;
    bal_d        = bal_q;
    not_enough_d = not_enough_q;
    err_d        = err_q;
    gnt_d        = gnt_q;
    ack_d        = ack_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          win_d = pick;
          op_d  = pick ? op1 : op0;
          amt_d = pick ? amt1 : amt0;
          gnt_d = pick ? 2'b10 : 2'b01;
        end
      end
      S_GRANT: begin
        if (!req[win_q]) begin
          gnt_d = 2'b00;
        end else begin
          // Commit on the way into EXEC so results are visible one cycle ahead of ack.
          case (op_q)
            OP_QUERY: begin
              not_enough_d = 1'b0;
              err_d        = 1'b0;
            end
            OP_DEP: begin
              not_enough_d = 1'b0;
              if (sum[BAL_W]) begin
                err_d = 1'b1;
              end else begin
                bal_d = sum[BAL_W-1:0];
                err_d = 1'b0;
              end
            end
            OP_WDR: begin
              err_d = 1'b0;
              if (amt_ext > bal_q) begin
                not_enough_d = 1'b1;
              end else begin
                bal_d        = bal_q - amt_ext;
                not_enough_d = 1'b0;
              end
            end
            default: begin
              not_enough_d = 1'b0;
              err_d        = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: begin
        gnt_d = 2'b00;
        ack_d = win_q ? 2'b10 : 2'b01;
      end
      S_RESP: begin
        if (!req[win_q]) ack_d = 2'b00;
      end
      default: begin
        gnt_d = 2'b00;
        ack_d = 2'b00;
      end
    endcase
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign balance_out = bal_q;
  assign not_enough  = not_enough_q;
  assign err         = err_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Self-checking bench for atm_account_arbiter: directed scenarios plus randomized
// transactions compared against an integer-arithmetic account model.
module tb_atm_account_arbiter;

  localparam int BAL_W = 8;
  localparam int AMT_W = 4;
  localparam int MAXB  = (1 << BAL_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       op0, op1;
  logic [AMT_W-1:0] amt0, amt1;
  logic [1:0]       gnt, ack;
  logic [BAL_W-1:0] balance_out;
  logic             not_enough, err;

  int n_tests = 0;
  int n_fail  = 0;

  int m_bal;
  bit m_ne, m_err;
  int m_last;

  atm_account_arbiter #(.BAL_W(BAL_W), .AMT_W(AMT_W), .INIT_BAL(20)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op0(op0), .amt0(amt0), .op1(op1), .amt1(amt1),
    .gnt(gnt), .ack(ack), .balance_out(balance_out),
    .not_enough(not_enough), .err(err)
  );

  always #5 clk = ~clk;

  // gnt and ack must each be at most one-hot and never both active
  always @(negedge clk) begin
    n_tests++;
    if ((gnt != 2'b00 && ack != 2'b00) || gnt == 2'b11 || ack == 2'b11) begin
      n_fail++;
      $display("FAIL onehot_excl: gnt=%b ack=%b required exclusive one-hot", gnt, ack);
    end
  end

  function automatic void m_apply(input int op, input int amt);
    case (op)
      0: begin m_ne = 0; m_err = 0; end
      1: begin
        m_ne = 0;
        if (m_bal + amt > MAXB) m_err = 1;
        else begin m_bal = m_bal + amt; m_err = 0; end
      end
      2: begin
        m_err = 0;
        if (amt > m_bal) m_ne = 1;
        else begin m_bal = m_bal - amt; m_ne = 0; end
      end
      default: begin m_ne = 0; m_err = 1; end
    endcase
  endfunction

  function automatic int m_pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return (m_last == 0) ? 1 : 0;
  endfunction

  function automatic logic [1:0] onehot(input int t);
    return (t == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_term(input int t, input logic [1:0] op, input logic [AMT_W-1:0] amt);
    if (t == 0) begin op0 = op; amt0 = amt; end
    else begin op1 = op; amt1 = amt; end
  endtask

  // Samples gnt at +1, results at +2, ack at +3 after the requesting edge.
  task automatic drive(output logic [1:0] g, output logic [BAL_W-1:0] b,
                       output logic ne, output logic er, output logic [1:0] a);
    step(); g = gnt;
    step(); b = balance_out; ne = not_enough; er = err;
    step(); a = ack;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 2'b00;
    op0 = 2'b00; op1 = 2'b00; amt0 = '0; amt1 = '0;
    step(); step();
    rst = 1'b1;
    m_bal = 20; m_ne = 0; m_err = 0; m_last = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_tests++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_tests++; if (balance_out !== 8'd20) begin n_fail++; $display("FAIL reset_bal: got %0d want 20", balance_out); end
    n_tests++; if ({not_enough, err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got ne=%b err=%b want 0 0", not_enough, err); end
  endtask

  task automatic test_basic_withdraw();
    logic [1:0] g, a; logic [BAL_W-1:0] b; logic ne, er;
    set_term(0, 2'b10, 4'd4);
    req = 2'b01;
    drive(g, b, ne, er, a);
    m_last = 0; m_apply(2, 4);
    n_tests++; if (g !== 2'b01) begin n_fail++; $display("FAIL basic_gnt: got %b want 01", g); end
    n_tests++; if (b !== 8'd16) begin n_fail++; $display("FAIL basic_bal: got %0d want 16", b); end
    n_tests++; if ({ne, er} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got ne=%b err=%b want 0 0", ne, er); end
    n_tests++; if (a !== 2'b01) begin n_fail++; $display("FAIL basic_ack: got %b want 01", a); end
    req = 2'b00;
    step();
    n_tests++; if (ack !== 2'b00) begin n_fail++; $display("FAIL basic_ack_drop: got %b want 00", ack); end
    step();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL basic_idle: got gnt %b want 00", gnt); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g, a; logic [BAL_W-1:0] b; logic ne, er;
    int w;
    do_reset();
    set_term(0, 2'b01, 4'd3);
    set_term(1, 2'b01, 4'd3);
    for (int round = 0; round < 2; round++) begin
      req = 2'b11;
      for (int j = 0; j < 2; j++) begin
        w = m_pick(req);
        m_last = w;
        m_apply(1, 3);
        drive(g, b, ne, er, a);
        n_tests++; if (g !== onehot(j)) begin n_fail++; $display("FAIL rr_gnt r%0d j%0d: got %b want %b", round, j, g, onehot(j)); end
        n_tests++; if (b !== BAL_W'(m_bal)) begin n_fail++; $display("FAIL rr_bal r%0d j%0d: got %0d want %0d", round, j, b, m_bal); end
        n_tests++; if (a !== onehot(j)) begin n_fail++; $display("FAIL rr_ack r%0d j%0d: got %b want %b", round, j, a, onehot(j)); end
        req[w] = 1'b0;
        step();
        n_tests++; if (ack !== 2'b00) begin n_fail++; $display("FAIL rr_ack_drop r%0d j%0d: got %b want 00", round, j, ack); end
      end
    end
  endtask

  task automatic test_withdraw_limits();
    logic [1:0] g, a; logic [BAL_W-1:0] b; logic ne, er;
    int amts[3]  = '{15, 15, 5};
    int exp_b[3] = '{5, 5, 0};
    bit exp_ne[3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_term(1, 2'b10, AMT_W'(amts[i]));
      req = 2'b10;
      drive(g, b, ne, er, a);
      m_last = 1; m_apply(2, amts[i]);
      n_tests++; if (b !== BAL_W'(exp_b[i])) begin n_fail++; $display("FAIL wdr_bal %0d: got %0d want %0d", i, b, exp_b[i]); end
      n_tests++; if (ne !== exp_ne[i] || er !== 1'b0) begin n_fail++; $display("FAIL wdr_flags %0d: got ne=%b err=%b want ne=%b err=0", i, ne, er, exp_ne[i]); end
      n_tests++; if (a !== 2'b10) begin n_fail++; $display("FAIL wdr_ack %0d: got %b want 10", i, a); end
      req = 2'b00;
      step();
    end
  endtask

  task automatic test_overflow();
    logic [1:0] g, a; logic [BAL_W-1:0] b; logic ne, er;
    logic [1:0] ops[5] = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b10};
    int amts[5]  = '{15, 5, 0, 0, 0};
    int exp_b[5] = '{250, 255, 255, 255, 255};
    bit exp_er[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_term(0, 2'b01, (i < 15) ? 4'd15 : 4'd5);
      req = 2'b01;
      drive(g, b, ne, er, a);
      req = 2'b00;
      step();
    end
    m_bal = 250; m_last = 0;
    n_tests++; if (b !== 8'd250) begin n_fail++; $display("FAIL ovf_prep: got %0d want 250", b); end
    for (int i = 0; i < 5; i++) begin
      set_term(0, ops[i], AMT_W'(amts[i]));
      req = 2'b01;
      drive(g, b, ne, er, a);
      m_apply(int'(ops[i]), amts[i]);
      n_tests++; if (b !== BAL_W'(exp_b[i])) begin n_fail++; $display("FAIL ovf_bal %0d: got %0d want %0d", i, b, exp_b[i]); end
      n_tests++; if (er !== exp_er[i] || ne !== 1'b0) begin n_fail++; $display("FAIL ovf_flags %0d: got err=%b ne=%b want err=%b ne=0", i, er, ne, exp_er[i]); end
      req = 2'b00;
      step();
    end
  endtask

  task automatic test_abort();
    set_term(0, 2'b01, 4'd1);
    req = 2'b01;
    step();
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL abort_gnt: got %b want 01", gnt); end
    m_last = 0;
    req = 2'b00;
    step();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL abort_gnt_clr: got %b want 00", gnt); end
    n_tests++; if (balance_out !== BAL_W'(m_bal)) begin n_fail++; $display("FAIL abort_bal: got %0d want %0d", balance_out, m_bal); end
    n_tests++; if (err !== m_err || not_enough !== m_ne) begin n_fail++; $display("FAIL abort_flags: got err=%b ne=%b want err=%b ne=%b", err, not_enough, m_err, m_ne); end
    step();
    n_tests++; if (ack !== 2'b00) begin n_fail++; $display("FAIL abort_no_ack: got %b want 00", ack); end
    set_term(0, 2'b00, 4'd0);
    set_term(1, 2'b00, 4'd0);
    req = 2'b11;
    step();
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL abort_ptr: got %b want 10", gnt); end
    m_last = 1; m_apply(0, 0);
    step(); step();
    req = 2'b00;
    step();
  endtask

  task automatic test_reset_exec();
    int exp_mid;
    set_term(0, 2'b10, 4'd3);
    req = 2'b01;
    exp_mid = (3 > m_bal) ? m_bal : m_bal - 3;
    step(); step();
    n_tests++; if (balance_out !== BAL_W'(exp_mid)) begin n_fail++; $display("FAIL rexec_commit: got %0d want %0d", balance_out, exp_mid); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (gnt !== 2'b00 || ack !== 2'b00) begin n_fail++; $display("FAIL rexec_hs: got gnt=%b ack=%b want 00 00", gnt, ack); end
    n_tests++; if (balance_out !== 8'd20) begin n_fail++; $display("FAIL rexec_bal: got %0d want 20", balance_out); end
    n_tests++; if ({not_enough, err} !== 2'b00) begin n_fail++; $display("FAIL rexec_flags: got ne=%b err=%b want 0 0", not_enough, err); end
    req = 2'b00;
    step();
    rst = 1'b1;
    m_bal = 20; m_ne = 0; m_err = 0; m_last = 1;
  endtask

  task automatic test_random();
    logic [1:0] g, a; logic [BAL_W-1:0] b; logic ne, er;
    int ops[2], amts[2];
    int w, nserve;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      for (int t = 0; t < 2; t++) begin
        ops[t]  = $urandom_range(0, 3);
        amts[t] = $urandom_range(0, 15);
        set_term(t, 2'(ops[t]), AMT_W'(amts[t]));
      end
      req = 2'($urandom_range(1, 3));
      nserve = (req == 2'b11) ? 2 : 1;
      for (int k = 0; k < nserve; k++) begin
        w = m_pick(req);
        m_last = w;
        m_apply(ops[w], amts[w]);
        drive(g, b, ne, er, a);
        n_tests++; if (g !== onehot(w)) begin n_fail++; $display("FAIL rand_gnt %0d.%0d: got %b want %b", i, k, g, onehot(w)); end
        n_tests++; if (b !== BAL_W'(m_bal)) begin n_fail++; $display("FAIL rand_bal %0d.%0d: got %0d want %0d", i, k, b, m_bal); end
        n_tests++; if (ne !== m_ne || er !== m_err) begin n_fail++; $display("FAIL rand_flags %0d.%0d: got ne=%b err=%b want ne=%b err=%b", i, k, ne, er, m_ne, m_err); end
        n_tests++; if (a !== onehot(w)) begin n_fail++; $display("FAIL rand_ack %0d.%0d: got %b want %b", i, k, a, onehot(w)); end
        req[w] = 1'b0;
        step();
        n_tests++; if (ack !== 2'b00) begin n_fail++; $display("FAIL rand_ack_drop %0d.%0d: got %b want 00", i, k, ack); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_withdraw();
    test_round_robin();
    test_withdraw_limits();
    test_overflow();
    test_abort();
    test_reset_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
